// File: rtl/send_sched_pkg.sv
// Shared types and widths for the send scheduler and its per-channel engine.
// The drop counter saturation helper lives here so the top stays a thin wrapper.
package send_sched_pkg;

    localparam int ADDR_W = 25;
    localparam int CNT_W  = 16;
    localparam int DROP_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } chan_state_e;

    // Both channels can each drop an echo and a periodic request in one cycle.
    function automatic logic [DROP_W-1:0] satAddDrops(
        input logic [DROP_W-1:0] cur,
        input logic [1:0]        dropA,
        input logic [1:0]        dropB
    );
        logic [2:0]        n;
        logic [DROP_W:0]   sum;
        n   = 3'(dropA[0]) + 3'(dropA[1]) + 3'(dropB[0]) + 3'(dropB[1]);
        sum = {1'b0, cur} + (DROP_W + 1)'(n);
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/send_scheduler_channel.sv
// One send channel: periodic timer, data_saved edge detect, pending flags,
// IDLE/ASSERT/GAP command FSM and completed-command counter.
module send_channel
    import send_sched_pkg::*;
#(
    parameter logic [31:0]       PERIOD    = 32'd8,
    parameter int unsigned       PULSE_LEN = 3,
    parameter int unsigned       GAP_LEN   = 16,
    parameter logic [ADDR_W-1:0] ADDR_PER  = 25'd1,
    parameter logic [ADDR_W-1:0] ADDR_ECHO = 25'd1,
    parameter bit                ONESHOT   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              data_saved_i,
    output logic              cmd_send_o,
    output logic [ADDR_W-1:0] start_ram_addr_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  sent_cnt_o,
    output logic [1:0]        drop_o
);

    localparam logic [31:0] PERIOD_LAST = PERIOD - 32'd1;
    localparam logic [31:0] PULSE_LAST  = 32'(PULSE_LEN) - 32'd1;
    localparam logic [31:0] GAP_LAST    = 32'(GAP_LEN) - 32'd1;

    logic [31:0]       timer_q, timer_d;
    logic              ds_q;
    logic              per_pend_q, per_pend_d;
    logic              echo_pend_q, echo_pend_d;
    logic              done_q;

    chan_state_e       state_q;
    logic [31:0]       phase_q;
    logic              cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  sent_q;

    logic wrap;
    logic per_fire;
    logic echo_fire;
    logic serve_echo;
    logic serve_per;

    assign wrap       = (timer_q == PERIOD_LAST);
    assign per_fire   = en_i & wrap & ~(ONESHOT & done_q);
    assign echo_fire  = en_i & data_saved_i & ~ds_q;
    assign serve_echo = en_i & (state_q == IDLE) & echo_pend_q;
    assign serve_per  = en_i & (state_q == IDLE) & ~echo_pend_q & per_pend_q;

    // A request that finds its flag still set (and not being served) is merged.
    assign drop_o = {per_fire & per_pend_q & ~serve_per,
                     echo_fire & echo_pend_q & ~serve_echo};

    always_comb begin
        timer_d     = wrap ? 32'd0 : timer_q + 32'd1;
        per_pend_d  = (per_pend_q & ~serve_per) | per_fire;
        echo_pend_d = (echo_pend_q & ~serve_echo) | echo_fire;
        if (!en_i) begin
            timer_d     = 32'd0;
            per_pend_d  = 1'b0;
            echo_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q     <= 32'd0;
            ds_q        <= 1'b0;
            per_pend_q  <= 1'b0;
            echo_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            ds_q        <= data_saved_i;
            per_pend_q  <= per_pend_d;
            echo_pend_q <= echo_pend_d;
            if (serve_per) begin
                done_q <= 1'b1;
            end
        end
    end

    // Losing enable aborts whatever is in flight without counting it as sent.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            phase_q <= 32'd0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            sent_q  <= '0;
        end else if (!en_i) begin
            state_q <= IDLE;
            phase_q <= 32'd0;
            cmd_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (serve_echo || serve_per) begin
                        state_q <= ASSERT;
                        phase_q <= 32'd0;
                        cmd_q   <= 1'b1;
                        addr_q  <= serve_echo ? ADDR_ECHO : ADDR_PER;
                    end
                end
                ASSERT: begin
                    if (phase_q == PULSE_LAST) begin
                        state_q <= GAP;
                        phase_q <= 32'd0;
                        cmd_q   <= 1'b0;
                        sent_q  <= sent_q + CNT_W'(1);
                    end else begin
                        phase_q <= phase_q + 32'd1;
                    end
                end
                GAP: begin
                    if (phase_q == GAP_LAST) begin
                        state_q <= IDLE;
                        phase_q <= 32'd0;
                    end else begin
                        phase_q <= phase_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    phase_q <= 32'd0;
                    cmd_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_send_o       = cmd_q;
    assign start_ram_addr_o = addr_q;
    assign busy_o           = (state_q != IDLE);
    assign sent_cnt_o       = sent_q;

endmodule

// File: rtl/send_scheduler.sv
// Two independent send channels gated by MAC/PHY readiness, plus a shared
// saturating counter of merged (dropped) duplicate requests.
module send_scheduler
    import send_sched_pkg::*;
#(
    parameter logic [31:0]       PERIOD_1    = 32'h05F5E100,
    parameter logic [31:0]       PERIOD_2    = 32'h06F5E100,
    parameter int unsigned       PULSE_LEN   = 3,
    parameter int unsigned       GAP_LEN     = 16,
    parameter logic [ADDR_W-1:0] ADDR_PER_1  = 25'd1,
    parameter logic [ADDR_W-1:0] ADDR_PER_2  = 25'd5,
    parameter logic [ADDR_W-1:0] ADDR_ECHO_1 = 25'd1,
    parameter logic [ADDR_W-1:0] ADDR_ECHO_2 = 25'd5,
    parameter logic [1:0]        ONESHOT     = 2'b10
) (
    input  logic              clk_50,
    input  logic              main_reset,
    input  logic              mac_inited,
    input  logic              rx_ready,
    input  logic [1:0]        data_saved,
    output logic              cmd_send_1,
    output logic              cmd_send_2,
    output logic [ADDR_W-1:0] start_ram_addr_1,
    output logic [ADDR_W-1:0] start_ram_addr_2,
    output logic [1:0]        busy,
    output logic [CNT_W-1:0]  sent_cnt_1,
    output logic [CNT_W-1:0]  sent_cnt_2,
    output logic [DROP_W-1:0] drop_cnt
);

    logic              en;
    logic [1:0]        drop_1;
    logic [1:0]        drop_2;
    logic              busy_1;
    logic              busy_2;
    logic [DROP_W-1:0] drop_cnt_q;

    assign en = mac_inited & rx_ready;

    send_channel #(
        .PERIOD    (PERIOD_1),
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN),
        .ADDR_PER  (ADDR_PER_1),
        .ADDR_ECHO (ADDR_ECHO_1),
        .ONESHOT   (ONESHOT[0])
    ) u_chan_1 (
        .clk_i            (clk_50),
        .rst_i            (main_reset),
        .en_i             (en),
        .data_saved_i     (data_saved[0]),
        .cmd_send_o       (cmd_send_1),
        .start_ram_addr_o (start_ram_addr_1),
        .busy_o           (busy_1),
        .sent_cnt_o       (sent_cnt_1),
        .drop_o           (drop_1)
    );

    send_channel #(
        .PERIOD    (PERIOD_2),
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN),
        .ADDR_PER  (ADDR_PER_2),
        .ADDR_ECHO (ADDR_ECHO_2),
        .ONESHOT   (ONESHOT[1])
    ) u_chan_2 (
        .clk_i            (clk_50),
        .rst_i            (main_reset),
        .en_i             (en),
        .data_saved_i     (data_saved[1]),
        .cmd_send_o       (cmd_send_2),
        .start_ram_addr_o (start_ram_addr_2),
        .busy_o           (busy_2),
        .sent_cnt_o       (sent_cnt_2),
        .drop_o           (drop_2)
    );

    always_ff @(posedge clk_50) begin
        if (main_reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= satAddDrops(drop_cnt_q, drop_1, drop_2);
        end
    end

    assign busy     = {busy_2, busy_1};
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_send_scheduler.sv
// Directed bench: expected command pulses are queued as stimulus is applied and
// a negedge monitor pops and compares them as the DUT raises cmd_send.
module tb_send_scheduler;

    logic        clk_50 = 1'b0;
    logic        main_reset;
    logic        mac_inited;
    logic        rx_ready;
    logic [1:0]  data_saved;
    logic        cmd_send_1;
    logic        cmd_send_2;
    logic [24:0] start_ram_addr_1;
    logic [24:0] start_ram_addr_2;
    logic [1:0]  busy;
    logic [15:0] sent_cnt_1;
    logic [15:0] sent_cnt_2;
    logic [7:0]  drop_cnt;

    localparam logic [24:0] ECHO_1 = 25'd33;
    localparam logic [24:0] ECHO_2 = 25'd37;

    send_scheduler #(
        .PERIOD_1    (32'd8),
        .PERIOD_2    (32'd12),
        .PULSE_LEN   (3),
        .GAP_LEN     (4),
        .ADDR_PER_1  (25'd1),
        .ADDR_PER_2  (25'd5),
        .ADDR_ECHO_1 (ECHO_1),
        .ADDR_ECHO_2 (ECHO_2),
        .ONESHOT     (2'b10)
    ) dut (
        .clk_50           (clk_50),
        .main_reset       (main_reset),
        .mac_inited       (mac_inited),
        .rx_ready         (rx_ready),
        .data_saved       (data_saved),
        .cmd_send_1       (cmd_send_1),
        .cmd_send_2       (cmd_send_2),
        .start_ram_addr_1 (start_ram_addr_1),
        .start_ram_addr_2 (start_ram_addr_2),
        .busy             (busy),
        .sent_cnt_1       (sent_cnt_1),
        .sent_cnt_2       (sent_cnt_2),
        .drop_cnt         (drop_cnt)
    );

    always #5 clk_50 = ~clk_50;

    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    typedef struct {
        int          atCycle;
        logic [24:0] addr;
        int          length;
    } pulse_t;

    pulse_t q1[$];
    pulse_t q2[$];
    pulse_t curExp[2];
    bit     curOk[2];
    int     pulseLen[2];
    logic   cmdPrev[2];
    bit     scoreOn = 1'b1;
    int     checks = 0;
    int     errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic applyStimulus(input logic mac, input logic rx, input logic [1:0] ds);
        mac_inited = mac;
        rx_ready   = rx;
        data_saved = ds;
    endtask

    task automatic expectPulse(input int ch, input int atCycle, input logic [24:0] addr, input int length);
        pulse_t e;
        e.atCycle = atCycle;
        e.addr    = addr;
        e.length  = length;
        if (ch == 1) q1.push_back(e);
        else         q2.push_back(e);
    endtask

    task automatic tickTo(input int target);
        while (cyc < target) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cmd1"},  32'(cmd_send_1), 32'd0);
        checkOutput({tag, "_cmd2"},  32'(cmd_send_2), 32'd0);
        checkOutput({tag, "_addr1"}, 32'(start_ram_addr_1), 32'd0);
        checkOutput({tag, "_addr2"}, 32'(start_ram_addr_2), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy), 32'd0);
        checkOutput({tag, "_sent1"}, 32'(sent_cnt_1), 32'd0);
        checkOutput({tag, "_sent2"}, 32'(sent_cnt_2), 32'd0);
        checkOutput({tag, "_drop"},  32'(drop_cnt), 32'd0);
    endtask

    task automatic monitorChannel(input int ch, input logic cmdNow, input logic [24:0] addrNow);
        pulse_t e;
        bit     got;
        if (cmdNow === 1'b1 && cmdPrev[ch] !== 1'b1) begin
            pulseLen[ch] = 1;
            curOk[ch]    = 1'b0;
            if (scoreOn) begin
                got = 1'b0;
                if (ch == 0 && q1.size() > 0) begin
                    e = q1.pop_front();
                    got = 1'b1;
                end else if (ch == 1 && q2.size() > 0) begin
                    e = q2.pop_front();
                    got = 1'b1;
                end
                if (!got) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pulse_ch%0d: pulse at cycle %0d addr %0d, expected none",
                             ch + 1, cyc, addrNow);
                end else begin
                    curExp[ch] = e;
                    curOk[ch]  = 1'b1;
                    checkOutput($sformatf("pulse_cycle_ch%0d", ch + 1), 32'(cyc), 32'(e.atCycle));
                    checkOutput($sformatf("pulse_addr_ch%0d", ch + 1), 32'(addrNow), 32'(e.addr));
                end
            end
        end else if (cmdNow === 1'b1) begin
            pulseLen[ch]++;
        end else if (cmdPrev[ch] === 1'b1 && curOk[ch] && scoreOn) begin
            checkOutput($sformatf("pulse_len_ch%0d", ch + 1), 32'(pulseLen[ch]), 32'(curExp[ch].length));
            curOk[ch] = 1'b0;
        end
        cmdPrev[ch] = cmdNow;
    endtask

    always @(negedge clk_50) begin
        monitorChannel(0, cmd_send_1, start_ram_addr_1);
        monitorChannel(1, cmd_send_2, start_ram_addr_2);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int b;
        main_reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 2'b00);
        tickTo(2);
        checkAllZero("reset");

        // Periodic sends on both channels; channel 2 is one-shot.
        main_reset = 1'b0;
        b = cyc;
        expectPulse(1, b + 9,  25'd1, 3);
        expectPulse(1, b + 17, 25'd1, 3);
        expectPulse(1, b + 25, 25'd1, 3);
        expectPulse(2, b + 13, 25'd5, 3);
        tickTo(b + 12);
        checkOutput("sent1_first", 32'(sent_cnt_1), 32'd1);
        tickTo(b + 13);
        checkOutput("busy_both", 32'(busy), 32'd3);
        checkOutput("addr1_hold", 32'(start_ram_addr_1), 32'd1);
        tickTo(b + 16);
        checkOutput("sent2_first", 32'(sent_cnt_2), 32'd1);
        tickTo(b + 30);
        applyStimulus(1'b0, 1'b1, 2'b00);
        tickTo(b + 31);
        checkOutput("s1_busy_off", 32'(busy), 32'd0);
        checkOutput("s1_sent1", 32'(sent_cnt_1), 32'd3);
        checkOutput("s1_drop", 32'(drop_cnt), 32'd0);

        // Two channel-2 edges during ASSERT: one extra command, one drop.
        b = cyc;
        applyStimulus(1'b1, 1'b1, 2'b00);
        expectPulse(2, b + 3,  ECHO_2, 3);
        expectPulse(2, b + 11, ECHO_2, 3);
        expectPulse(1, b + 9,  25'd1, 3);
        expectPulse(1, b + 17, 25'd1, 3);
        tickTo(b + 1); applyStimulus(1'b1, 1'b1, 2'b10);
        tickTo(b + 2); applyStimulus(1'b1, 1'b1, 2'b00);
        tickTo(b + 3); applyStimulus(1'b1, 1'b1, 2'b10);
        tickTo(b + 4); applyStimulus(1'b1, 1'b1, 2'b00);
        tickTo(b + 5); applyStimulus(1'b1, 1'b1, 2'b10);
        checkOutput("s3_drop_before", 32'(drop_cnt), 32'd0);
        tickTo(b + 6); applyStimulus(1'b1, 1'b1, 2'b00);
        checkOutput("s3_drop_after", 32'(drop_cnt), 32'd1);
        tickTo(b + 20);
        applyStimulus(1'b0, 1'b1, 2'b00);
        tickTo(b + 21);
        checkOutput("s3_sent1", 32'(sent_cnt_1), 32'd5);
        checkOutput("s3_sent2", 32'(sent_cnt_2), 32'd3);

        // Echo and periodic request on channel 1 in the same cycle.
        b = cyc;
        applyStimulus(1'b1, 1'b1, 2'b00);
        expectPulse(1, b + 9,  ECHO_1, 3);
        expectPulse(1, b + 17, 25'd1, 3);
        tickTo(b + 7); applyStimulus(1'b1, 1'b1, 2'b01);
        tickTo(b + 8); applyStimulus(1'b1, 1'b1, 2'b00);
        tickTo(b + 15);
        checkOutput("s2_drop_pre", 32'(drop_cnt), 32'd1);
        tickTo(b + 16);
        checkOutput("s2_drop_merge", 32'(drop_cnt), 32'd2);
        tickTo(b + 21);
        applyStimulus(1'b0, 1'b1, 2'b00);
        tickTo(b + 22);
        checkOutput("s2_sent1", 32'(sent_cnt_1), 32'd7);

        // rx_ready lost in the second ASSERT cycle aborts the command.
        b = cyc;
        applyStimulus(1'b1, 1'b1, 2'b00);
        expectPulse(1, b + 9, 25'd1, 2);
        tickTo(b + 10); applyStimulus(1'b1, 1'b0, 2'b00);
        tickTo(b + 11);
        checkOutput("abort_cmd1", 32'(cmd_send_1), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_sent1", 32'(sent_cnt_1), 32'd7);
        tickTo(b + 13); applyStimulus(1'b1, 1'b1, 2'b00);
        expectPulse(1, b + 22, 25'd1, 3);
        tickTo(b + 21);
        checkOutput("restart_busy", 32'(busy), 32'd0);
        tickTo(b + 25);
        checkOutput("restart_sent1", 32'(sent_cnt_1), 32'd8);
        tickTo(b + 26); applyStimulus(1'b0, 1'b1, 2'b00);
        tickTo(b + 28);

        // Flood both channels with edges to saturate the drop counter.
        scoreOn = 1'b0;
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'b1, 1'b1, (i % 2 == 0) ? 2'b11 : 2'b00);
            @(posedge clk_50);
            #1;
        end
        applyStimulus(1'b0, 1'b1, 2'b00);
        @(posedge clk_50); #1;
        @(posedge clk_50); #1;
        checkOutput("drop_saturated", 32'(drop_cnt), 32'd255);
        scoreOn = 1'b1;

        // Reset in the middle of GAP clears every output.
        b = cyc;
        applyStimulus(1'b1, 1'b1, 2'b00);
        expectPulse(1, b + 9, 25'd1, 3);
        tickTo(b + 13);
        main_reset = 1'b1;
        tickTo(b + 14);
        checkAllZero("gap_reset");
        main_reset = 1'b0;
        tickTo(b + 16);

        checkOutput("queue1_empty", 32'(q1.size()), 32'd0);
        checkOutput("queue2_empty", 32'(q2.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/send_scheduler.md
SEND_SCHEDULER -- requirements
Module: send_scheduler

Interface
REQ-001 Parameter PERIOD_1, default 32'h05F5E100: periodic send interval for channel 1, in clk_50 cycles.
REQ-002 Parameter PERIOD_2, default 32'h06F5E100: periodic send interval for channel 2, in clk_50 cycles.
REQ-003 Parameter PULSE_LEN, default 3: number of cycles cmd_send stays high per command.
REQ-004 Parameter GAP_LEN, default 16: number of low cycles enforced after each command.
REQ-005 Parameters ADDR_PER_1 = 25'd1, ADDR_PER_2 = 25'd5, ADDR_ECHO_1 = 25'd1, ADDR_ECHO_2 = 25'd5: RAM start addresses per channel and source.
REQ-006 Parameter ONESHOT, default 2'b10: bit n set limits channel n+1 to a single periodic send after reset.
REQ-007 Clock and reset are fixed: one clock, clk_50; reset main_reset, synchronous, active-high.
REQ-008 clk_50  in  1  system clock.
REQ-009 main_reset  in  1  synchronous active-high reset.
REQ-010 mac_inited  in  1  MAC configuration complete.
REQ-011 rx_ready  in  1  PHY reset controller reports RX ready.
REQ-012 data_saved  in  2  per-channel "received packet stored" level; bit 0 = channel 1.
REQ-013 cmd_send_1, cmd_send_2  out  1 each  send command to the packet senders.
REQ-014 start_ram_addr_1, start_ram_addr_2  out  25 each  start address qualifying the matching cmd_send.
REQ-015 busy  out  2  channel not in IDLE.
REQ-016 sent_cnt_1, sent_cnt_2  out  16 each  completed commands, wrapping.
REQ-017 drop_cnt  out  8  merged (dropped) duplicate requests across both channels, saturating at 255.

Function
REQ-018 The block SHALL derive en = mac_inited & rx_ready; all timers and state machines SHALL advance only while en = 1.
REQ-019 Per channel, the periodic timer SHALL count 0..PERIOD-1; at PERIOD-1 it SHALL wrap to 0 and set per_pend, unless the ONESHOT bit is set and that channel's one periodic send has already been issued.
REQ-020 A rising edge on data_saved[n], compared with a registered copy, SHALL set echo_pend for that channel.
REQ-021 A request arriving while the same pend flag is already set SHALL be merged and SHALL increment drop_cnt.
REQ-022 Channel FSM states SHALL be IDLE, ASSERT and GAP.
REQ-023 IDLE -> ASSERT SHALL occur when any pend flag is set; echo_pend SHALL take priority over per_pend; the served flag SHALL clear on the transition; the other flag SHALL stay set.
REQ-024 On entering ASSERT, cmd_send and start_ram_addr SHALL update in the same cycle, one cycle after the pend flag is observed.
REQ-025 ASSERT SHALL last exactly PULSE_LEN cycles, then go to GAP.
REQ-026 GAP SHALL last exactly GAP_LEN cycles with cmd_send = 0, then return to IDLE; sent_cnt SHALL increment on ASSERT -> GAP.
REQ-027 start_ram_addr SHALL hold its last value outside ASSERT.
REQ-028 If en falls at any point, the block SHALL, on the next cycle: deassert cmd_send, force IDLE, clear both pend flags and reset timers to 0; sent_cnt SHALL NOT increment for an aborted command.
REQ-029 Channels SHALL be fully independent; simultaneous commands on both channels are legal.

Reset
REQ-030 On main_reset, all outputs SHALL be 0: cmd_send, start_ram_addr, busy and all counters.
REQ-031 On main_reset, FSMs SHALL go to IDLE, pend flags and the oneshot-done flags SHALL clear, and the data_saved edge registers SHALL load 0.

Structure
REQ-032 Package send_sched_pkg SHALL hold the state enum {IDLE, ASSERT, GAP}, ADDR_W = 25 and CNT_W = 16.
REQ-033 A single sub-module, send_channel (timer, edge detect, pend flags, FSM, sent counter), SHALL be instantiated twice; drop_cnt saturation SHALL live in the top.

Verification (PERIOD_1 = 8, PERIOD_2 = 12, PULSE_LEN = 3, GAP_LEN = 4)
REQ-034 en held at 1 from reset -> cmd_send_1 high for 3 cycles starting cycle 9, addr = 1; repeats every 8 cycles; sent_cnt_1 increments each time.
REQ-035 ONESHOT = 2'b10 -> exactly one cmd_send_2 pulse with addr = 5; afterwards only data_saved[1] edges trigger sends.
REQ-036 data_saved[0] edge in the same cycle per_pend sets -> echo command first, periodic command immediately after its GAP; two commands total.
REQ-037 Two data_saved[1] edges while channel 2 is in ASSERT -> one extra command; drop_cnt = 1.
REQ-038 rx_ready dropped in the 2nd ASSERT cycle -> cmd_send low next cycle, busy = 0, sent_cnt unchanged; timer restarts from 0 when rx_ready returns.
REQ-039 main_reset asserted mid-GAP -> all outputs 0 next cycle; 300 forced drops -> drop_cnt = 255.
